// File: rtl/wall_collision_det_if.sv
// Wall-block stream from the area renderer: frame markers plus a valid/ready position beat.
interface wall_collision_det_if;
  logic        frame_start;
  logic        frame_end;
  logic        wall_valid;
  logic        wall_ready;
  logic [11:0] wall_x_pos;
  logic [11:0] wall_y_pos;

  modport master (
    output frame_start, frame_end, wall_valid, wall_x_pos, wall_y_pos,
    input  wall_ready
  );

  modport slave (
    input  frame_start, frame_end, wall_valid, wall_x_pos, wall_y_pos,
    output wall_ready
  );
endinterface

// File: rtl/wall_collision_det.sv
// Per-frame hero/wall collision detector producing a registered up/down/left/right vector.
// Optional screen-edge bits are enabled with `define WALL_COLLISION_EDGE_EN.
module wall_collision_det #(
  parameter int BLOCK_SIZE = 48,
  parameter int STEP       = 1,
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600
) (
  input  logic                 clk,
  input  logic                 rst,
  wall_collision_det_if.slave  wall_if,
  input  logic [11:0]          hero_x_pos,
  input  logic [11:0]          hero_y_pos,
  output logic [3:0]           collision,
  output logic                 collision_valid
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StPublish} state_e;

  localparam logic signed [12:0] BS = 13'(BLOCK_SIZE);
  localparam logic signed [12:0] ST = 13'(STEP);

  state_e      state_q, state_d;
  logic        drain_q, drain_d;
  logic        load_hero;
  logic        publish;
  logic        accept;

  logic [11:0] hero_x_q, hero_y_q;
  logic        s1_valid_q;
  logic [11:0] s1_x_q, s1_y_q;
  logic [3:0]  acc_q;
  logic [3:0]  hit;
  logic [3:0]  edge_bits;

  assign wall_if.wall_ready = (state_q == StAccum);
  assign accept             = wall_if.wall_valid && wall_if.wall_ready;

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    load_hero = 1'b0;
    publish   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wall_if.frame_start) begin
          state_d   = StAccum;
          load_hero = 1'b1;
        end
      end
      StAccum: begin
        if (wall_if.frame_start) begin
          load_hero = 1'b1;
        end else if (wall_if.frame_end) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        if (wall_if.frame_start) begin
          state_d   = StAccum;
          load_hero = 1'b1;
        end else if (drain_q) begin
          state_d = StPublish;
          publish = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      StPublish: begin
        if (wall_if.frame_start) begin
          state_d   = StAccum;
          load_hero = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hero_x_q <= '0;
      hero_y_q <= '0;
    end else if (load_hero) begin
      hero_x_q <= hero_x_pos;
      hero_y_q <= hero_y_pos;
    end
  end

  // S1: register the accepted beat; a restart flushes anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= accept && !load_hero;
      if (accept) begin
        s1_x_q <= wall_if.wall_x_pos;
        s1_y_q <= wall_if.wall_y_pos;
      end
    end
  end

  function automatic logic overlap(logic signed [12:0] hx, logic signed [12:0] hy,
                                   logic signed [12:0] wx, logic signed [12:0] wy);
    return (hx < wx + BS) && (wx < hx + BS) && (hy < wy + BS) && (wy < hy + BS);
  endfunction

  // S2: shifted hero boxes in signed space so a move past zero stays negative.
  always_comb begin
    logic signed [12:0] hx, hy, wx, wy;
    hx     = $signed({1'b0, hero_x_q});
    hy     = $signed({1'b0, hero_y_q});
    wx     = $signed({1'b0, s1_x_q});
    wy     = $signed({1'b0, s1_y_q});
    hit    = '0;
    hit[3] = overlap(hx, hy - ST, wx, wy);
    hit[2] = overlap(hx, hy + ST, wx, wy);
    hit[1] = overlap(hx - ST, hy, wx, wy);
    hit[0] = overlap(hx + ST, hy, wx, wy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (load_hero) begin
      acc_q <= '0;
    end else if (s1_valid_q) begin
      acc_q <= acc_q | hit;
    end
  end

`ifdef WALL_COLLISION_EDGE_EN
  localparam logic [13:0] STEP14  = 14'(STEP);
  localparam logic [13:0] BSST14  = 14'(BLOCK_SIZE + STEP);
  localparam logic [13:0] SCR_W14 = 14'(SCREEN_W);
  localparam logic [13:0] SCR_H14 = 14'(SCREEN_H);

  always_comb begin
    edge_bits    = '0;
    edge_bits[3] = {2'b00, hero_y_q} < STEP14;
    edge_bits[2] = ({2'b00, hero_y_q} + BSST14) > SCR_H14;
    edge_bits[1] = {2'b00, hero_x_q} < STEP14;
    edge_bits[0] = ({2'b00, hero_x_q} + BSST14) > SCR_W14;
  end
`else
  assign edge_bits = '0;
`endif

  // Registered on entry to PUBLISH so the valid pulse and new vector line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision       <= '0;
      collision_valid <= 1'b0;
    end else begin
      collision_valid <= publish;
      if (publish) begin
        collision <= acc_q | edge_bits;
      end
    end
  end

endmodule

// File: tb/tb_wall_collision_det.sv
// Randomized scoreboard bench for wall_collision_det against a geometric reference model.
module tb_wall_collision_det;
  localparam int BS = 48;
  localparam int ST = 1;
  localparam int SW = 800;
  localparam int SH = 600;

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hero_x_pos = '0;
  logic [11:0] hero_y_pos = '0;
  logic [3:0]  collision;
  logic        collision_valid;

  wall_collision_det_if wif ();

  wall_collision_det #(
    .BLOCK_SIZE(BS),
    .STEP      (ST),
    .SCREEN_W  (SW),
    .SCREEN_H  (SH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wall_if        (wif),
    .hero_x_pos     (hero_x_pos),
    .hero_y_pos     (hero_y_pos),
    .collision      (collision),
    .collision_valid(collision_valid)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   fw_x[$];
  int   fw_y[$];
  int   cur_hx, cur_hy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit ov(int ax, int ay, int bx, int by);
    return (ax < bx + BS) && (bx < ax + BS) && (ay < by + BS) && (by < ay + BS);
  endfunction

  // Bit order up, down, left, right; each bit tests the hero moved one step that way.
  function automatic logic [3:0] model();
    int dx[4] = '{0, 0, -ST, ST};
    int dy[4] = '{-ST, ST, 0, 0};
    logic [3:0] r = '0;
    for (int d = 0; d < 4; d++)
      for (int w = 0; w < fw_x.size(); w++)
        if (ov(cur_hx + dx[d], cur_hy + dy[d], fw_x[w], fw_y[w])) r[3-d] = 1'b1;
`ifdef WALL_COLLISION_EDGE_EN
    if (cur_hy < ST) r[3] = 1'b1;
    if (cur_hy + BS + ST > SH) r[2] = 1'b1;
    if (cur_hx < ST) r[1] = 1'b1;
    if (cur_hx + BS + ST > SW) r[0] = 1'b1;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.val = model();
    e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic start_frame(input int hx, input int hy);
    hero_x_pos = 12'(hx);
    hero_y_pos = 12'(hy);
    cur_hx = hx;
    cur_hy = hy;
    fw_x.delete();
    fw_y.delete();
    wif.frame_start = 1'b1;
    tick();
    wif.frame_start = 1'b0;
  endtask

  task automatic send_wall(input int x, input int y, input bit last);
    int budget = 0;
    wif.wall_valid = 1'b1;
    wif.wall_x_pos = 12'(x);
    wif.wall_y_pos = 12'(y);
    while (!wif.wall_ready && budget < 10) begin
      tick();
      budget++;
    end
    if (!wif.wall_ready) chk("ready_timeout", 0, 1);
    fw_x.push_back(x);
    fw_y.push_back(y);
    wif.frame_end = last;
    if (last) push_exp();
    tick();
    wif.wall_valid = 1'b0;
    wif.frame_end  = 1'b0;
  endtask

  task automatic end_frame(input bit expect_pulse);
    wif.frame_end = 1'b1;
    if (expect_pulse) push_exp();
    tick();
    wif.frame_end = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    if (sb.size() != 0) chk("pulse_timeout", sb.size(), 0);
    repeat (2) tick();
  endtask

  // Monitor: pops an expectation for every pulse, checks value and arrival cycle,
  // and checks the published vector is held between pulses.
  logic [3:0] last_pub = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pub = '0;
      end else if (collision_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("collision", int'(collision), int'(e.val));
          chk("latency_cycle", cyc, e.cyc);
          last_pub = e.val;
        end
      end else begin
        if (collision != last_pub) chk("collision_hold", int'(collision), int'(last_pub));
      end
    end
  end

  initial begin
    wif.frame_start = 1'b0;
    wif.frame_end   = 1'b0;
    wif.wall_valid  = 1'b0;
    wif.wall_x_pos  = '0;
    wif.wall_y_pos  = '0;
    repeat (3) tick();
    chk("rst_collision", int'(collision), 0);
    chk("rst_valid", int'(collision_valid), 0);
    chk("rst_ready", int'(wif.wall_ready), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed geometry cases around hero (96,96).
    start_frame(96, 96); send_wall(144, 96, 0); end_frame(1); wait_drain();
    start_frame(96, 96); send_wall(145, 96, 0); end_frame(1); wait_drain();
    start_frame(96, 96); send_wall(96, 48, 0); end_frame(1); wait_drain();
    start_frame(96, 96); send_wall(48, 96, 0); send_wall(96, 144, 0); end_frame(1);
    wait_drain();
    start_frame(96, 96); send_wall(144, 96, 1); wait_drain();

    // Abort mid-frame after a colliding wall: only the restarted frame publishes.
    start_frame(96, 96); send_wall(144, 96, 0);
    start_frame(96, 96); end_frame(1); wait_drain();

    // Zero walls, and a hero against the screen corner.
    start_frame(300, 300); end_frame(1); wait_drain();
    start_frame(0, 552); end_frame(1); wait_drain();

    // frame_end in IDLE is ignored.
    end_frame(0); repeat (6) tick();

    // A beat held while not ready is not consumed and lands once ACCUM starts.
    wif.wall_valid = 1'b1;
    wif.wall_x_pos = 12'd144;
    wif.wall_y_pos = 12'd96;
    repeat (3) begin
      chk("ready_idle", int'(wif.wall_ready), 0);
      tick();
    end
    start_frame(96, 96);
    send_wall(144, 96, 0); end_frame(1); wait_drain();

    // Back-to-back: frame_start during PUBLISH goes straight to ACCUM.
    start_frame(96, 96); send_wall(96, 48, 0); end_frame(1);
    repeat (2) tick();
    start_frame(96, 96); send_wall(48, 96, 0); end_frame(1); wait_drain();

    // Randomized frames with walls clustered near the hero.
    for (int f = 0; f < 40; f++) begin
      int hx = $urandom_range(60, 700);
      int hy = $urandom_range(60, 500);
      int nw = $urandom_range(0, 5);
      bit coincide = $urandom_range(0, 1) == 1;
      start_frame(hx, hy);
      for (int w = 0; w < nw; w++) begin
        int wx = hx + $urandom_range(0, 110) - 55;
        int wy = hy + $urandom_range(0, 110) - 55;
        if ($urandom_range(0, 2) == 0) tick();
        send_wall(wx, wy, coincide && (w == nw - 1));
      end
      if (!(coincide && nw > 0)) end_frame(1);
      wait_drain();
    end

    // Async reset during DRAIN clears outputs at once; a later lone frame_end publishes nothing.
    start_frame(96, 96); send_wall(144, 96, 0); end_frame(0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_collision", int'(collision), 0);
    chk("async_rst_valid", int'(collision_valid), 0);
    chk("async_rst_ready", int'(wif.wall_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    end_frame(0);
    repeat (8) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
